// File: rtl/runtime_pkg.sv
// Shared types and defaults for the two-context runtime scheduler.
package runtime_pkg;

  localparam int unsigned SLEEP_W_DEFAULT = 16;
  localparam int unsigned PC_W            = 32;
  localparam logic [PC_W-1:0] RESET_VEC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    CTX_IDLE  = 2'b00,
    CTX_RUN   = 2'b01,
    CTX_SLEEP = 2'b10,
    CTX_HALT  = 2'b11
  } ctx_state_t;

  // Accepted system event, already resolved to the context it applies to
  typedef struct packed {
    logic exit_ev;
    logic sleep_ev;
    logic start_ev;
  } ctx_cmd_t;

  // A context may be started by BCPU/BCPUJ only when it is not live
  function automatic logic ctx_free(input ctx_state_t s);
    return (s == CTX_IDLE) || (s == CTX_HALT);
  endfunction

  function automatic logic ctx_live(input ctx_state_t s);
    return (s == CTX_RUN) || (s == CTX_SLEEP);
  endfunction

endpackage

// File: rtl/runtime_context.sv
// One hardware context: IDLE/RUN/SLEEP/HALT state plus its sleep countdown.
module runtime_context
  import runtime_pkg::*;
#(
  parameter int unsigned SLEEP_W     = SLEEP_W_DEFAULT,
  parameter ctx_state_t  RESET_STATE = CTX_IDLE
) (
  input  logic               clk,
  input  logic               reset,
  input  ctx_cmd_t           cmd,
  input  logic [SLEEP_W-1:0] sleep_cycles,
  output ctx_state_t         state,
  output ctx_state_t         state_next_c,
  output logic               wake_c
);

  logic [SLEEP_W-1:0] count;
  logic [SLEEP_W-1:0] count_next;

  // Next state; the sleep counter runs every edge independent of stall
  always_comb begin
    state_next_c = state;
    count_next   = count;
    wake_c       = 1'b0;
    unique case (state)
      CTX_RUN: begin
        if (cmd.exit_ev) begin
          state_next_c = CTX_HALT;
        end else if (cmd.sleep_ev) begin
          state_next_c = CTX_SLEEP;
          count_next   = (sleep_cycles == '0) ? SLEEP_W'(1) : sleep_cycles;
        end
      end
      CTX_SLEEP: begin
        count_next = count - SLEEP_W'(1);
        if ((count == SLEEP_W'(1)) || (count == '0)) begin
          state_next_c = CTX_RUN;
          wake_c       = 1'b1;
          count_next   = '0;
        end
      end
      CTX_IDLE, CTX_HALT: begin
        if (cmd.start_ev) begin
          state_next_c = CTX_RUN;
        end
      end
      default: begin
        state_next_c = state;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RESET_STATE;
      count <= '0;
    end else begin
      state <= state_next_c;
      count <= count_next;
    end
  end

endmodule

// File: rtl/runtime_scheduler.sv
// Two-context runtime scheduler: system-event decode, round-robin issue
// selection and the PC load pulse for a newly started context.
module runtime_scheduler
  import runtime_pkg::*;
#(
  parameter int unsigned      SLEEP_W   = SLEEP_W_DEFAULT,
  parameter logic [PC_W-1:0]  RESET_VEC = RESET_VEC_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               sys_valid,
  input  logic               sys_sleep,
  input  logic               sys_exit,
  input  logic               sys_bcpu,
  input  logic               sys_bcpuj,
  input  logic [SLEEP_W-1:0] sleep_cycles,
  input  logic [PC_W-1:0]    start_pc,
  output logic               runtime,
  output logic               issue_valid,
  output logic               pc_load,
  output logic               pc_load_ctx,
  output logic [PC_W-1:0]    pc_load_value,
  output logic [3:0]         ctx_state,
  output logic               all_halted
);

  ctx_state_t state        [2];
  ctx_state_t state_next_c [2];
  logic       wake_c       [2];
  ctx_cmd_t   cmd          [2];

  logic other;
  logic accept_c;
  logic exit_c;
  logic sleep_c;
  logic jump_c;
  logic boot_c;
  logic start_c;
  logic other_eligible_c;
  logic runtime_sel_c;
  logic issue_sel_c;

  assign other = ~runtime;

  // Priority decode EXIT > SLEEP > BCPUJ > BCPU, routed to the target context
  always_comb begin
    accept_c = sys_valid & issue_valid & ~stall;
    exit_c   = accept_c & sys_exit;
    sleep_c  = accept_c & ~sys_exit & sys_sleep;
    jump_c   = accept_c & ~sys_exit & ~sys_sleep & sys_bcpuj;
    boot_c   = accept_c & ~sys_exit & ~sys_sleep & ~sys_bcpuj & sys_bcpu;
    start_c  = (jump_c | boot_c) & ctx_free(state[other]);
    for (int i = 0; i < 2; i++) begin
      cmd[i].exit_ev  = exit_c  & (runtime == 1'(i));
      cmd[i].sleep_ev = sleep_c & (runtime == 1'(i));
      cmd[i].start_ev = start_c & (other   == 1'(i));
    end
  end

  runtime_context #(
    .SLEEP_W     (SLEEP_W),
    .RESET_STATE (CTX_RUN)
  ) u_ctx0 (
    .clk          (clk),
    .reset        (reset),
    .cmd          (cmd[0]),
    .sleep_cycles (sleep_cycles),
    .state        (state[0]),
    .state_next_c (state_next_c[0]),
    .wake_c       (wake_c[0])
  );

  runtime_context #(
    .SLEEP_W     (SLEEP_W),
    .RESET_STATE (CTX_IDLE)
  ) u_ctx1 (
    .clk          (clk),
    .reset        (reset),
    .cmd          (cmd[1]),
    .sleep_cycles (sleep_cycles),
    .state        (state[1]),
    .state_next_c (state_next_c[1]),
    .wake_c       (wake_c[1])
  );

  // A context waking from sleep on this edge waits for the following selection
  always_comb begin
    other_eligible_c = (state_next_c[other] == CTX_RUN) && !wake_c[other];
    runtime_sel_c    = other_eligible_c ? other : runtime;
    issue_sel_c      = (state_next_c[runtime_sel_c] == CTX_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      runtime     <= 1'b0;
      issue_valid <= 1'b1;
    end else if (!stall) begin
      runtime     <= runtime_sel_c;
      issue_valid <= issue_sel_c;
    end
  end

  // One-cycle PC load for the context just started; value is zero otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_load       <= 1'b0;
      pc_load_ctx   <= 1'b0;
      pc_load_value <= '0;
    end else if (start_c) begin
      pc_load       <= 1'b1;
      pc_load_ctx   <= other;
      pc_load_value <= jump_c ? start_pc : RESET_VEC;
    end else begin
      pc_load       <= 1'b0;
      pc_load_ctx   <= 1'b0;
      pc_load_value <= '0;
    end
  end

  assign ctx_state  = {state[1], state[0]};
  assign all_halted = !ctx_live(state[0]) && !ctx_live(state[1]);

endmodule

// File: tb/tb_runtime_scheduler.sv
// Scoreboard bench for runtime_scheduler: a behavioural model predicts every
// cycle's outputs into a queue that an independent monitor drains.
module tb_runtime_scheduler;

  localparam int IDLE = 0;
  localparam int RUN  = 1;
  localparam int SLP  = 2;
  localparam int HALT = 3;
  localparam logic [31:0] RVEC = 32'h0000_1000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        sys_valid;
  logic        sys_sleep;
  logic        sys_exit;
  logic        sys_bcpu;
  logic        sys_bcpuj;
  logic [15:0] sleep_cycles;
  logic [31:0] start_pc;
  logic        runtime;
  logic        issue_valid;
  logic        pc_load;
  logic        pc_load_ctx;
  logic [31:0] pc_load_value;
  logic [3:0]  ctx_state;
  logic        all_halted;

  typedef struct packed {
    logic        rt;
    logic        iv;
    logic        pl;
    logic        plc;
    logic [31:0] plv;
    logic [3:0]  st;
    logic        ah;
  } snap_t;

  snap_t exp_q[$];
  int    total;
  int    passed;

  // Reference model state
  int          m_st[2];
  int          m_cnt[2];
  int          m_rt;
  int          m_iv;
  int          m_pl;
  int          m_plc;
  logic [31:0] m_plv;

  runtime_scheduler #(
    .SLEEP_W   (16),
    .RESET_VEC (RVEC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .sys_valid     (sys_valid),
    .sys_sleep     (sys_sleep),
    .sys_exit      (sys_exit),
    .sys_bcpu      (sys_bcpu),
    .sys_bcpuj     (sys_bcpuj),
    .sleep_cycles  (sleep_cycles),
    .start_pc      (start_pc),
    .runtime       (runtime),
    .issue_valid   (issue_valid),
    .pc_load       (pc_load),
    .pc_load_ctx   (pc_load_ctx),
    .pc_load_value (pc_load_value),
    .ctx_state     (ctx_state),
    .all_halted    (all_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_st[0] = RUN;  m_st[1] = IDLE;
    m_cnt[0] = 0;   m_cnt[1] = 0;
    m_rt = 0; m_iv = 1;
    m_pl = 0; m_plc = 0; m_plv = '0;
  endtask

  task automatic model_tick(input bit stl, sv, sl, ex, b, bj, input int sc, input logic [31:0] spc);
    int nst[2];
    bit woke[2];
    int cur;
    int oth;
    nst = m_st;
    woke[0] = 0; woke[1] = 0;
    for (int i = 0; i < 2; i++) begin
      if (m_st[i] == SLP) begin
        m_cnt[i] = m_cnt[i] - 1;
        if (m_cnt[i] == 0) begin
          nst[i]  = RUN;
          woke[i] = 1;
        end
      end
    end
    m_pl = 0; m_plc = 0; m_plv = '0;
    if (sv && m_iv == 1 && !stl) begin
      cur = m_rt;
      oth = 1 - m_rt;
      if (ex) nst[cur] = HALT;
      else if (sl) begin
        nst[cur]   = SLP;
        m_cnt[cur] = (sc == 0) ? 1 : sc;
      end else if (bj || b) begin
        if (m_st[oth] == IDLE || m_st[oth] == HALT) begin
          nst[oth] = RUN;
          m_pl  = 1;
          m_plc = oth;
          m_plv = bj ? spc : RVEC;
        end
      end
    end
    if (!stl) begin
      oth = 1 - m_rt;
      if (nst[oth] == RUN && !woke[oth]) m_rt = oth;
      m_iv = (nst[m_rt] == RUN) ? 1 : 0;
    end
    m_st = nst;
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s.rt  = 1'(m_rt);
    s.iv  = 1'(m_iv);
    s.pl  = 1'(m_pl);
    s.plc = 1'(m_plc);
    s.plv = m_plv;
    s.st  = {2'(m_st[1]), 2'(m_st[0])};
    s.ah  = ((m_st[0] == IDLE || m_st[0] == HALT) && (m_st[1] == IDLE || m_st[1] == HALT)) ? 1'b1 : 1'b0;
    return s;
  endfunction

  // Drive one cycle (inputs applied just after the falling edge) and predict it
  task automatic step(input bit rst, stl, sv, sl, ex, b, bj, input int sc, input logic [31:0] spc);
    #1;
    reset = rst; stall = stl; sys_valid = sv; sys_sleep = sl;
    sys_exit = ex; sys_bcpu = b; sys_bcpuj = bj;
    sleep_cycles = 16'(sc); start_pc = spc;
    if (rst) model_reset();
    else model_tick(stl, sv, sl, ex, b, bj, sc, spc);
    exp_q.push_back(model_snap());
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
  endtask

  // Idle until the model says context c is selected, then confirm the DUT agrees
  task automatic wait_rt(input int c);
    for (int k = 0; k < 8; k++) begin
      if (!(m_rt == c && m_iv == 1)) idle(1);
    end
    check("reach_runtime", 32'(runtime), 32'(c));
  endtask

  always @(negedge clk) begin
    snap_t e;
    snap_t g;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g.rt = runtime; g.iv = issue_valid; g.pl = pc_load; g.plc = pc_load_ctx;
      g.plv = pc_load_value; g.st = ctx_state; g.ah = all_halted;
      total++;
      if (g === e) passed++;
      else $display("FAIL snapshot t=%0t got rt=%0d iv=%0d pl=%0d plc=%0d plv=%h st=%b ah=%0d want rt=%0d iv=%0d pl=%0d plc=%0d plv=%h st=%b ah=%0d",
                    $time, g.rt, g.iv, g.pl, g.plc, g.plv, g.st, g.ah,
                    e.rt, e.iv, e.pl, e.plc, e.plv, e.st, e.ah);
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    total = 0; passed = 0;
    reset = 1'b1; stall = 1'b0; sys_valid = 1'b0; sys_sleep = 1'b0;
    sys_exit = 1'b0; sys_bcpu = 1'b0; sys_bcpuj = 1'b0;
    sleep_cycles = '0; start_pc = '0;
    model_reset();
    @(negedge clk);

    // Reset and release
    step(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    idle(1);
    check("release_ctx_state", 32'(ctx_state), 32'h1);
    check("release_runtime", 32'(runtime), 32'h0);
    check("release_issue_valid", 32'(issue_valid), 32'h1);
    check("release_all_halted", 32'(all_halted), 32'h0);

    // BCPUJ from ctx0 starts ctx1 at 0x400
    step(0, 0, 1, 0, 0, 0, 1, 0, 32'h0000_0400);
    check("bcpuj_pc_load", 32'(pc_load), 32'h1);
    check("bcpuj_pc_load_ctx", 32'(pc_load_ctx), 32'h1);
    check("bcpuj_pc_load_value", pc_load_value, 32'h0000_0400);
    idle(1);
    check("bcpuj_pulse_end", 32'(pc_load), 32'h0);
    check("bcpuj_value_clear", pc_load_value, 32'h0);
    idle(3);

    // Ctx1 sleeps 3 cycles, then 0 (treated as 1)
    wait_rt(1);
    step(0, 0, 1, 1, 0, 0, 0, 3, 32'h0);
    check("sleep3_ctx1_state", 32'(ctx_state[3:2]), 32'h2);
    idle(6);
    wait_rt(1);
    step(0, 0, 1, 1, 0, 0, 0, 0, 32'h0);
    check("sleep0_ctx1_state", 32'(ctx_state[3:2]), 32'h2);
    idle(4);

    // Stall freezes selection and blocks EXIT
    step(0, 1, 0, 0, 0, 0, 0, 0, 32'h0);
    step(0, 1, 1, 0, 1, 0, 0, 0, 32'h0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 32'h0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 32'h0);
    check("stall_exit_ignored", 32'(ctx_state), 32'h5);
    idle(3);

    // EXIT and BCPU together: EXIT wins
    step(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    idle(1);
    step(0, 0, 1, 0, 1, 1, 0, 0, 32'h0);
    check("exit_bcpu_ctx_state", 32'(ctx_state), 32'h3);
    check("exit_bcpu_all_halted", 32'(all_halted), 32'h1);
    check("exit_bcpu_issue_valid", 32'(issue_valid), 32'h0);
    check("exit_bcpu_no_pc_load", 32'(pc_load), 32'h0);
    idle(2);

    // BCPU from a fresh reset loads RESET_VEC
    step(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    idle(1);
    step(0, 0, 1, 0, 0, 1, 0, 0, 32'hdead_beef);
    check("bcpu_value", pc_load_value, RVEC);
    idle(2);

    // Reset during a 10-cycle sleep aborts it
    step(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    idle(1);
    step(0, 0, 1, 1, 0, 0, 0, 10, 32'h0);
    idle(2);
    step(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    check("sleep_reset_ctx_state", 32'(ctx_state), 32'h1);
    check("sleep_reset_pc_load", 32'(pc_load), 32'h0);
    idle(12);
    check("sleep_reset_no_wake", 32'(ctx_state), 32'h1);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(99) < 2, $urandom_range(99) < 20, $urandom_range(99) < 60,
           $urandom_range(99) < 20, $urandom_range(99) < 8, $urandom_range(99) < 25,
           $urandom_range(99) < 20, int'($urandom_range(5)), $urandom);
    end
    idle(2);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/runtime_scheduler.md
RUNTIME_SCHEDULER -- requirements
Module: runtime_scheduler

Interface
REQ-001 The block SHALL have parameter SLEEP_W, default 16, giving the sleep counter width.
REQ-002 The block SHALL have parameter RESET_VEC, default 32'h0000_0000, giving the start PC used by BCPU.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port stall, input, 1: pipeline stall; freezes the issue selection.
REQ-006 The block SHALL have port sys_valid, input, 1: qualifies the sys_* strobes for the context on runtime.
REQ-007 The block SHALL have ports sys_sleep, sys_exit, sys_bcpu and sys_bcpuj, each input, 1: decoded SLEEP, EXIT, BCPU and BCPUJ.
REQ-008 The block SHALL have port sleep_cycles, input, SLEEP_W: SLEEP duration in cycles.
REQ-009 The block SHALL have port start_pc, input, 32: BCPUJ target PC.
REQ-010 The block SHALL have port runtime, output, 1: context selected to issue.
REQ-011 The block SHALL have port issue_valid, output, 1: the selected context is RUN.
REQ-012 The block SHALL have ports pc_load (output, 1), pc_load_ctx (output, 1) and pc_load_value (output, 32): a one-cycle PC load pulse for a started context.
REQ-013 The block SHALL have port ctx_state, output, 4: {state1, state0}.
REQ-014 The block SHALL have port all_halted, output, 1: neither context is RUN or SLEEP.

Function
REQ-015 Each context SHALL hold a 2-bit state: IDLE=00, RUN=01, SLEEP=10, HALT=11.
REQ-016 A system event SHALL be accepted only when sys_valid=1, issue_valid=1 and stall=0, and SHALL apply to context runtime.
REQ-017 When several strobes are asserted, priority SHALL be EXIT > SLEEP > BCPUJ > BCPU, and only one SHALL take effect.
REQ-018 EXIT SHALL move the current context to HALT on the accepting edge.
REQ-019 SLEEP SHALL move the current context to SLEEP and load its counter with sleep_cycles, using 1 when sleep_cycles=0.
REQ-020 A SLEEP counter SHALL decrement every edge, regardless of stall; the edge taking it from 1 to 0 SHALL set that context to RUN, giving exactly N cycles asleep.
REQ-021 BCPU/BCPUJ SHALL start the other context only if it is IDLE or HALT: that context becomes RUN, and on the next cycle pc_load=1, pc_load_ctx=other and pc_load_value=RESET_VEC (BCPU) or start_pc as sampled at acceptance (BCPUJ).
REQ-022 BCPU/BCPUJ aimed at a RUN or SLEEP context SHALL be ignored, with no state change and no pc_load.
REQ-023 pc_load SHALL be a single-cycle pulse; pc_load_value SHALL be 0 when pc_load=0.
REQ-024 On each edge with stall=0, runtime SHALL become ~runtime if the other context's next state is RUN, else hold; issue_valid SHALL become (next state of the new runtime == RUN).
REQ-025 With stall=1, runtime and issue_valid SHALL hold, and a context woken during the stall SHALL become selectable at the first unstalled edge.
REQ-026 A context woken on the same edge as a selection SHALL be eligible at the next selection, not the current one.
REQ-027 When no context is RUN, issue_valid SHALL be 0 and runtime SHALL hold its last value.
REQ-028 all_halted SHALL be combinational from ctx_state.

Reset
REQ-029 While reset=1: context0=RUN, context1=IDLE, runtime=0, issue_valid=1, pc_load=0, pc_load_ctx=0, pc_load_value=0 and both counters=0.
REQ-030 Reset asserted mid-sleep or mid-pulse SHALL abort immediately, with no pc_load after release.

Structure
REQ-031 The state encodings and the SLEEP_W and RESET_VEC defaults SHALL live in shared package runtime_pkg.
REQ-032 The per-context FSM and sleep counter SHALL be sub-module runtime_context, instantiated twice; arbitration and pc_load logic SHALL remain in the top.

Verification
REQ-033 Release reset -> runtime=0, issue_valid=1, ctx_state=4'b0001 and all_halted=0 on the first edge.
REQ-034 Ctx0 issues BCPUJ with start_pc=32'h0000_0400 -> next cycle pc_load=1, pc_load_ctx=1, pc_load_value=32'h400; runtime then alternates 0,1,0,1.
REQ-035 Ctx1 issues SLEEP with sleep_cycles=3 while ctx0 runs -> runtime stays 0 for 3 cycles, then ctx1 returns to RUN and alternation resumes; the same check with sleep_cycles=0 gives 1 cycle asleep.
REQ-036 Both contexts RUN with stall=1 held for 4 cycles and sys_exit pulsed during the stall -> runtime frozen and the EXIT ignored.
REQ-037 Ctx0 asserts sys_exit and sys_bcpu together -> ctx0=HALT, ctx1 stays IDLE, no pc_load, all_halted=1 and issue_valid=0.
REQ-038 Assert reset 2 cycles into a 10-cycle sleep -> reset state as in REQ-029 and no wake-up event afterwards.
